// File: rtl/uart_rx_fsm_if.sv
// UART RX control-to-datapath bundle: counter, sampler,
// deserializer and checker strobes plus the results fed back.
//   edge_cnt/bit_cnt     : counter state (datapath -> fsm)
//   strt_glitch/par_err/stp_err : checker results (datapath -> fsm)
//   enable/reset_cnt/dat_samp_en/deser_en/*_chk_en : fsm -> datapath
interface uart_rx_fsm_if;
    logic [3:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       enable;
    logic       reset_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;

    modport master (
        input  edge_cnt, bit_cnt,
        input  strt_glitch, par_err, stp_err,
        output enable, reset_cnt, dat_samp_en, deser_en,
        output strt_chk_en, par_chk_en, stp_chk_en
    );

    modport slave (
        output edge_cnt, bit_cnt,
        output strt_glitch, par_err, stp_err,
        input  enable, reset_cnt, dat_samp_en, deser_en,
        input  strt_chk_en, par_chk_en, stp_chk_en
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start, 8 data bits, optional parity, stop.
// Ports: clk, rst (async active-low), RX_IN, PAR_EN, Prescale[4:0],
//   dp (uart_rx_fsm_if.master: counter/sampler/checker controls),
//   data_valid, parity_error, framing_error (1-cycle pulses), break_det.
// Build option: define UART_RX_BREAK_DET_EN to add the line-break state.
module uart_rx_fsm (
    input  logic                clk,
    input  logic                rst,
    input  logic                RX_IN,
    input  logic                PAR_EN,
    input  logic [4:0]          Prescale,
    uart_rx_fsm_if.master       dp,
    output logic                data_valid,
    output logic                parity_error,
    output logic                framing_error,
    output logic                break_det
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
`ifdef UART_RX_BREAK_DET_EN
        ,
        S_BREAK
`endif
    } state_t;

    state_t state_q, state_d;
    logic   par_e_q, par_e_d;
    logic   stp_e_q, stp_e_d;
    logic   par_en_q, par_en_d;
    logic   bit_end;

    assign bit_end = ({1'b0, dp.edge_cnt} == Prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            par_e_q  <= 1'b0;
            stp_e_q  <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            par_e_q  <= par_e_d;
            stp_e_q  <= stp_e_d;
            par_en_q <= par_en_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        par_e_d        = par_e_q;
        stp_e_d        = stp_e_q;
        par_en_d       = par_en_q;
        dp.enable      = 1'b0;
        dp.reset_cnt   = 1'b0;
        dp.dat_samp_en = 1'b0;
        dp.deser_en    = 1'b0;
        dp.strt_chk_en = 1'b0;
        dp.par_chk_en  = 1'b0;
        dp.stp_chk_en  = 1'b0;
        data_valid     = 1'b0;
        parity_error   = 1'b0;
        framing_error  = 1'b0;
        break_det      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                dp.enable    = 1'b1;
                dp.reset_cnt = 1'b1;
                par_en_d     = PAR_EN;
                if (!RX_IN) begin
                    state_d = S_START;
                    par_e_d = 1'b0;
                    stp_e_d = 1'b0;
                end
            end
            S_START: begin
                dp.enable      = 1'b1;
                dp.dat_samp_en = 1'b1;
                if (bit_end) begin
                    dp.strt_chk_en = 1'b1;
                    state_d = dp.strt_glitch ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                dp.enable      = 1'b1;
                dp.dat_samp_en = 1'b1;
                dp.deser_en    = bit_end;
                if (bit_end && dp.bit_cnt == 4'd8) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                dp.enable      = 1'b1;
                dp.dat_samp_en = 1'b1;
                if (bit_end) begin
                    dp.par_chk_en = 1'b1;
                    par_e_d       = dp.par_err;
                    state_d       = S_STOP;
                end
            end
            S_STOP: begin
                dp.enable      = 1'b1;
                dp.dat_samp_en = 1'b1;
                if (bit_end) begin
                    dp.stp_chk_en = 1'b1;
                    stp_e_d       = dp.stp_err;
                    state_d       = S_DONE;
`ifdef UART_RX_BREAK_DET_EN
                    // Stop bit missing and line still low: a break.
                    if (dp.stp_err && !RX_IN) begin
                        state_d = S_BREAK;
                    end
`endif
                end
            end
            S_DONE: begin
                dp.enable     = 1'b1;
                dp.reset_cnt  = 1'b1;
                data_valid    = !par_e_q && !stp_e_q;
                parity_error  = par_e_q;
                framing_error = stp_e_q;
                par_en_d      = PAR_EN;
                if (!RX_IN) begin
                    // Next start bit already on the line.
                    state_d = S_START;
                    par_e_d = 1'b0;
                    stp_e_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK: begin
                // Counter held while low so bit_end times the
                // first bit after the line returns high.
                dp.enable    = 1'b1;
                dp.reset_cnt = !RX_IN;
                break_det    = 1'b1;
                if (RX_IN && bit_end) begin
                    state_d = S_DONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: schedules frames as
// per-cycle stimulus, predicts strobe/pulse cycles from frame timing.
module tb_uart_rx_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic [4:0] Prescale;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       break_det;

    always #5 clk = ~clk;

    uart_rx_fsm_if dp_if ();

    uart_rx_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .Prescale      (Prescale),
        .dp            (dp_if),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .break_det     (break_det)
    );

    int checks   = 0;
    int failures = 0;

    bit rx_q[$], sg_q[$], pe_q[$], se_q[$], rn_q[$], pen_q[$];
    int pre_q[$];

    int e_dv[$], e_pe[$], e_fe[$], e_ds[$];
    int e_sc[$], e_pc[$], e_tc[$], e_bk[$];
    int a_dv[$], a_pe[$], a_fe[$], a_ds[$];
    int a_sc[$], a_pc[$], a_tc[$], a_bk[$];

    int cnt_e, cnt_b;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(bit rx, bit sg, bit pe, bit se, bit rn, bit pen, int p);
        rx_q.push_back(rx);
        sg_q.push_back(sg);
        pe_q.push_back(pe);
        se_q.push_back(se);
        rn_q.push_back(rn);
        pen_q.push_back(pen);
        pre_q.push_back(p);
    endtask

    task automatic idle(int n, int p);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), p);
    endtask

    // Line level t cycles after the first low sample.
    function automatic bit line(int t, int p, bit sg, bit par,
                                logic [7:0] d, bit pe);
        int k;
        if (sg) return (t >= 3);
        if (t <= p + 1) return 1'b0;
        k = (t - p - 2) / p;
        if (k < 8) return d[k];
        if (k == 8 && par) return (^d) ^ pe;
        return 1'b1;
    endfunction

    task automatic add_frame(int p, bit par, logic [7:0] d, bit sg,
                             bit pe, bit se, bit flip, int abort_t);
        int base, len, lim, c;
        bit pen;
        base = rx_q.size();
        len  = sg ? p + 2 : (par ? 11 : 10) * p + 2;
        lim  = (abort_t > 0) ? abort_t : len + 1;
        for (int t = 0; t < len && t < lim; t++) begin
            pen = (t == 0 || !flip) ? par : 1'($urandom_range(0, 1));
            push(line(t, p, sg, par, d, pe), sg, pe, se, 1'b1, pen, p);
        end
        if (abort_t > 0)
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, par, p);
        lim = base + lim;
        c = base + p + 1;
        if (c < lim) e_sc.push_back(c);
        if (sg) return;
        for (int k = 1; k <= 8; k++) begin
            c = base + p + 1 + k * p;
            if (c < lim) e_ds.push_back(c);
        end
        c = base + p + 1 + 9 * p;
        if (par && c < lim) e_pc.push_back(c);
        c = base + p + 1 + (par ? 10 : 9) * p;
        if (c < lim) e_tc.push_back(c);
        c = base + len;
        if (c < lim) begin
            if (!(par && pe) && !se) e_dv.push_back(c);
            if (par && pe) e_pe.push_back(c);
            if (se) e_fe.push_back(c);
        end
    endtask

    // Line held low 20 bit times with a stop error, then released.
    task automatic add_break(int p);
        int base, len, b2;
        base = rx_q.size();
`ifdef UART_RX_BREAK_DET_EN
        len = 21 * p + 1;
`else
        len = 20 * p + 4;
`endif
        for (int t = 0; t < len; t++)
            push(t >= 20 * p, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, p);
        e_sc.push_back(base + p + 1);
        for (int k = 1; k <= 8; k++)
            e_ds.push_back(base + p + 1 + k * p);
        e_tc.push_back(base + 10 * p + 1);
`ifdef UART_RX_BREAK_DET_EN
        for (int c = base + 10 * p + 2; c <= base + 21 * p; c++)
            e_bk.push_back(c);
        e_fe.push_back(base + 21 * p + 1);
`else
        b2 = base + 10 * p + 2;
        e_fe.push_back(b2);
        e_sc.push_back(b2 + p + 1);
        for (int k = 1; k <= 8; k++)
            e_ds.push_back(b2 + p + 1 + k * p);
        e_tc.push_back(b2 + 10 * p + 1);
        e_fe.push_back(b2 + 10 * p + 2);
`endif
    endtask

    task automatic run();
        int n;
        n = rx_q.size();
        cnt_e = 0;
        cnt_b = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst      = rn_q[c];
            RX_IN    = rx_q[c];
            PAR_EN   = pen_q[c];
            Prescale = 5'(pre_q[c]);
            if (!rn_q[c]) begin
                cnt_e = 0;
                cnt_b = 0;
            end
            dp_if.edge_cnt    = 4'(cnt_e);
            dp_if.bit_cnt     = 4'(cnt_b);
            dp_if.strt_glitch = sg_q[c];
            dp_if.par_err     = pe_q[c];
            dp_if.stp_err     = se_q[c];
            #1;
            if (!rst) begin
                chk("rst_enable", dp_if.enable, 1);
                chk("rst_reset_cnt", dp_if.reset_cnt, 1);
                chk("rst_others", {dp_if.dat_samp_en, dp_if.deser_en,
                    dp_if.strt_chk_en, dp_if.par_chk_en, dp_if.stp_chk_en,
                    data_valid, parity_error, framing_error, break_det}, 0);
            end
            if (data_valid === 1'b1)        a_dv.push_back(c);
            if (parity_error === 1'b1)      a_pe.push_back(c);
            if (framing_error === 1'b1)     a_fe.push_back(c);
            if (dp_if.deser_en === 1'b1)    a_ds.push_back(c);
            if (dp_if.strt_chk_en === 1'b1) a_sc.push_back(c);
            if (dp_if.par_chk_en === 1'b1)  a_pc.push_back(c);
            if (dp_if.stp_chk_en === 1'b1)  a_tc.push_back(c);
            if (break_det === 1'b1)         a_bk.push_back(c);
            // Environment model of the shared edge/bit counter.
            if (!rst) begin
                cnt_e = 0;
                cnt_b = 0;
            end else if (dp_if.enable === 1'b1) begin
                if (dp_if.reset_cnt === 1'b1) begin
                    cnt_e = 0;
                    cnt_b = 0;
                end else if (cnt_e == pre_q[c]) begin
                    cnt_e = 1;
                    cnt_b = (cnt_b + 1) & 15;
                end else begin
                    cnt_e = cnt_e + 1;
                end
            end
        end
    endtask

    task automatic cmpq(string tag, input int ex[$], input int ac[$]);
        int m;
        chk({tag, "_count"}, ac.size(), ex.size());
        m = (ac.size() < ex.size()) ? ac.size() : ex.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_cycle[%0d]", tag, i), ac[i], ex[i]);
    endtask

    initial begin
        int p, gap;
        bit par, sg, pe, se, fl;
        rst = 1'b0;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        Prescale = 5'd8;
        dp_if.edge_cnt = '0;
        dp_if.bit_cnt = '0;
        dp_if.strt_glitch = 1'b0;
        dp_if.par_err = 1'b0;
        dp_if.stp_err = 1'b0;

        for (int i = 0; i < 3; i++)
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        idle(4, 8);
        add_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 8);
        add_frame(8, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle(3, 8);
        add_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 8);
        add_frame(4, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_frame(4, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 4);
        add_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
        idle(2, 8);
        add_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3, 8);
        add_frame(6, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        idle(2, 6);
        add_frame(5, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle(2, 5);
        add_frame(7, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(2, 7);
        add_frame(7, 1'b1, 8'h24, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle(2, 7);
        add_break(8);
        idle(4, 8);
        for (int i = 0; i < 25; i++) begin
            p   = $urandom_range(4, 15);
            par = 1'($urandom_range(0, 1));
            sg  = ($urandom_range(0, 7) == 0);
            pe  = ($urandom_range(0, 3) == 0);
            se  = ($urandom_range(0, 3) == 0);
            fl  = 1'($urandom_range(0, 1));
            add_frame(p, par, 8'($urandom), sg, pe, se, fl, 0);
            gap = sg ? $urandom_range(1, 3) : $urandom_range(0, 2);
            idle(gap, p);
        end
        idle(3, 8);

        run();

        cmpq("data_valid", e_dv, a_dv);
        cmpq("parity_error", e_pe, a_pe);
        cmpq("framing_error", e_fe, a_fe);
        cmpq("deser_en", e_ds, a_ds);
        cmpq("strt_chk_en", e_sc, a_sc);
        cmpq("par_chk_en", e_pc, a_pc);
        cmpq("stp_chk_en", e_tc, a_tc);
        cmpq("break_det", e_bk, a_bk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
